// File: rtl/reset_sync_sequencer_pkg.sv
// Shared types and helpers for the reset-release sequencer.
package reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    SYNC    = 2'd1,
    STRETCH = 2'd2,
    RUN     = 2'd3
  } rst_seq_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reset_sync_sequencer_if.sv
// Software reset handshake and domain reset status of one clock domain.
interface reset_sync_sequencer_if;

  logic sw_rst_req;
  logic rst_out;
  logic rst_done;
  logic sw_rst_ack;
  logic busy;

  modport master (
    output sw_rst_req,
    input  rst_out,
    input  rst_done,
    input  sw_rst_ack,
    input  busy
  );

  modport slave (
    input  sw_rst_req,
    output rst_out,
    output rst_done,
    output sw_rst_ack,
    output busy
  );

endinterface

// File: rtl/reset_sync_sequencer_sync_chain.sv
// Release synchronizer: a constant 1 shifts in once rst drops; async clear on rst.
module reset_sync_chain #(
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic [STAGES-1:0] q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  assign chain_d = {chain_q[STAGES-2:0], 1'b1};

  // Shift register, cleared asynchronously while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q;

endmodule

// File: rtl/reset_sync_sequencer.sv
// Domain reset sequencer: async assert, synchronized and stretched release,
// plus a software reset request/acknowledge path that bypasses the synchronizer.
module reset_sync_sequencer
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int STRETCH_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  reset_sync_sequencer_if.slave  bus
);

  localparam int               CNT_W      = cnt_width(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STRETCH_CYCLES);

  rst_seq_state_e   state_q;
  rst_seq_state_e   state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sw_flag_q;
  logic             sw_flag_d;
  logic             rst_out_q;
  logic             rst_out_d;
  logic             rst_done_q;
  logic             rst_done_d;
  logic             sw_rst_ack_q;
  logic             sw_rst_ack_d;
  logic             busy_q;
  logic             busy_d;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_unused;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk (clk),
    .rst (rst),
    .q   (sync_chain)
  );

  // Only the thermometer tap feeding the last stage decides the transition.
  assign sync_unused = ^sync_chain;

  // State, counter, flag and output flops, all cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HOLD;
      cnt_q        <= CNT_RELOAD;
      sw_flag_q    <= 1'b0;
      rst_out_q    <= 1'b1;
      rst_done_q   <= 1'b0;
      sw_rst_ack_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sw_flag_q    <= sw_flag_d;
      rst_out_q    <= rst_out_d;
      rst_done_q   <= rst_done_d;
      sw_rst_ack_q <= sw_rst_ack_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, stretch counter and software-reset flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sw_flag_d = sw_flag_q;
    case (state_q)
      HOLD: begin
        state_d = SYNC;
      end
      SYNC: begin
        // The last stage loads 1 on this edge, so stretching starts here.
        if (sync_chain[SYNC_STAGES-2]) begin
          state_d = STRETCH;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = SYNC;
        end
      end
      STRETCH: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d   = RUN;
          cnt_d     = CNT_RELOAD;
          sw_flag_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (bus.sw_rst_req) begin
          state_d   = STRETCH;
          cnt_d     = CNT_RELOAD;
          sw_flag_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = HOLD;
        cnt_d     = CNT_RELOAD;
        sw_flag_d = 1'b0;
      end
    endcase
  end

  // Output flop inputs, derived from the transition being taken.
  always_comb begin
    rst_out_d    = (state_d != RUN);
    busy_d       = (state_d != RUN);
    rst_done_d   = (state_q == STRETCH) && (state_d == RUN);
    sw_rst_ack_d = rst_done_d && sw_flag_q;
  end

  assign bus.rst_out    = rst_out_q;
  assign bus.rst_done   = rst_done_q;
  assign bus.sw_rst_ack = sw_rst_ack_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_reset_sync_sequencer.sv
// Scoreboard bench: stimulus queues expected rst_out edges, a monitor matches them.
module tb_reset_sync_sequencer;

  localparam int FALL = 0;
  localparam int RISE = 1;

  typedef struct {
    int   dut;
    int   kind;
    int   cyc;
    logic ack;
  } ev_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  ev_t  sb[$];
  logic prev_ro[2];
  logic prev_bz[2];

  reset_sync_sequencer_if if0();
  reset_sync_sequencer_if if1();

  reset_sync_sequencer u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (if0)
  );

  reset_sync_sequencer #(
    .SYNC_STAGES    (2),
    .STRETCH_CYCLES (1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input int id);
    n_chk++;
    n_err++;
    $display("FAIL %s: dut %0d produced an event at cycle %0d with nothing expected", nm, id, cyc);
  endtask

  task automatic push(input int d, input int k, input int c, input logic a);
    ev_t e;
    e.dut  = d;
    e.kind = k;
    e.cyc  = c;
    e.ack  = a;
    sb.push_back(e);
  endtask

  task automatic observe(input int id, input logic ro, input logic dn, input logic ak,
                         input logic bz, input logic rin);
    ev_t e;
    if (rin === 1'b0 && prev_ro[id] === 1'b0 && ro === 1'b1) begin
      if (sb.size() == 0) begin
        unexpected("rise_unexpected", id);
      end else begin
        e = sb.pop_front();
        check("rise_dut", id, e.dut);
        check("rise_kind", RISE, e.kind);
        check("rise_cycle", cyc, e.cyc);
        check("rise_busy", bz, 1'b1);
      end
    end else if ((prev_ro[id] === 1'b1 && ro === 1'b0) || dn === 1'b1 || ak === 1'b1) begin
      if (sb.size() == 0) begin
        unexpected("fall_unexpected", id);
      end else begin
        e = sb.pop_front();
        check("fall_dut", id, e.dut);
        check("fall_kind", FALL, e.kind);
        check("fall_cycle", cyc, e.cyc);
        check("fall_rst_out", ro, 1'b0);
        check("fall_rst_done", dn, 1'b1);
        check("fall_sw_rst_ack", ak, e.ack);
        check("fall_busy", bz, 1'b0);
        check("busy_before_fall", prev_bz[id], 1'b1);
      end
    end
    prev_ro[id] = ro;
    prev_bz[id] = bz;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_events", sb.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    observe(0, if0.rst_out, if0.rst_done, if0.sw_rst_ack, if0.busy, rst0);
    observe(1, if1.rst_out, if1.rst_done, if1.sw_rst_ack, if1.busy, rst1);
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "time limit reached");
  end

  initial begin
    int e;
    int rel;
    prev_ro[0] = 1'b1;
    prev_ro[1] = 1'b1;
    prev_bz[0] = 1'b1;
    prev_bz[1] = 1'b1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    if0.sw_rst_req = 1'b0;
    if1.sw_rst_req = 1'b0;
    #1;
    rst0 = 1'b1;
    rst1 = 1'b1;
    #1;
    check("reset_rst_out0", if0.rst_out, 1'b1);
    check("reset_rst_done0", if0.rst_done, 1'b0);
    check("reset_ack0", if0.sw_rst_ack, 1'b0);
    check("reset_busy0", if0.busy, 1'b1);
    check("reset_rst_out1", if1.rst_out, 1'b1);
    check("reset_busy1", if1.busy, 1'b1);

    // Power-on: release after 5 cycles, rst_out falls on edge 19.
    repeat (5) @(negedge clk);
    rst0 = 1'b0;
    rel  = cyc;
    push(0, FALL, rel + 19, 1'b0);
    drain(40);

    // Single-cycle software request.
    if0.sw_rst_req = 1'b1;
    e = cyc + 1;
    push(0, RISE, e, 1'b0);
    push(0, FALL, e + 16, 1'b1);
    @(negedge clk);
    if0.sw_rst_req = 1'b0;
    drain(40);

    // Request held across the ack: second reset starts on the following edge.
    if0.sw_rst_req = 1'b1;
    e = cyc + 1;
    push(0, RISE, e, 1'b0);
    push(0, FALL, e + 16, 1'b1);
    push(0, RISE, e + 17, 1'b0);
    push(0, FALL, e + 33, 1'b1);
    repeat (34) @(negedge clk);
    if0.sw_rst_req = 1'b0;
    drain(10);
    repeat (20) @(negedge clk);

    // Async reset in the middle of a software stretch: no ack afterwards.
    if0.sw_rst_req = 1'b1;
    e = cyc + 1;
    push(0, RISE, e, 1'b0);
    @(negedge clk);
    if0.sw_rst_req = 1'b0;
    repeat (4) @(negedge clk);
    rst0 = 1'b1;
    #1;
    check("mid_stretch_rst_out", if0.rst_out, 1'b1);
    check("mid_stretch_busy", if0.busy, 1'b1);
    check("mid_stretch_done", if0.rst_done, 1'b0);
    check("mid_stretch_ack", if0.sw_rst_ack, 1'b0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rel  = cyc;
    push(0, FALL, rel + 19, 1'b0);
    drain(40);

    // Sub-cycle glitch on rst from RUN asserts rst_out with no clock edge.
    #1;
    rst0 = 1'b1;
    #2;
    check("glitch_rst_out", if0.rst_out, 1'b1);
    check("glitch_busy", if0.busy, 1'b1);
    rst0 = 1'b0;
    rel  = cyc;
    push(0, RISE, rel + 1, 1'b0);
    push(0, FALL, rel + 19, 1'b0);
    drain(40);

    // Request while synchronizing is ignored.
    rst0 = 1'b1;
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rel  = cyc;
    push(0, FALL, rel + 19, 1'b0);
    @(negedge clk);
    if0.sw_rst_req = 1'b1;
    @(negedge clk);
    if0.sw_rst_req = 1'b0;
    drain(40);
    repeat (25) @(negedge clk);

    // Minimum parameters: 2 stages, stretch of 1.
    rst1 = 1'b0;
    rel  = cyc;
    push(1, FALL, rel + 3, 1'b0);
    drain(10);
    if1.sw_rst_req = 1'b1;
    e = cyc + 1;
    push(1, RISE, e, 1'b0);
    push(1, FALL, e + 1, 1'b1);
    @(negedge clk);
    if1.sw_rst_req = 1'b0;
    drain(10);
    repeat (5) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
